multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Control unit for the multicycle RV32I datapath; the producer side of the ALU's ula_control interface.
//  Moore FSM sequences fetch/decode/execute/memory/writeback; an ALU decoder drives ula_control.
//  Executed subset: lw, sw, R-type, I-type ALU, beq, jal. Any other opcode halts the core in TRAP.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk          in   1  clock, all state updates on rising edge
//  reset        in   1  asynchronous, active-high; forces state FETCH
//  op           in   7  instr[6:0] from instruction register
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30]
//  zero         in   1  ALU result == 0
//  mem_ready    in   1  memory access completes this cycle
//  ula_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  alu_src_a    out  2  00 PC, 01 oldPC, 10 rs1
//  alu_src_b    out  2  00 rs2, 01 imm, 10 const 4
//  result_src   out  2  00 ALUOut, 01 mem data, 10 ALU result
//  imm_src      out  2  00 I, 01 S, 10 B, 11 J (from op, combinational)
//  adr_src      out  1  0 PC, 1 ALUOut
//  ir_write, pc_write, reg_write, mem_write  out  1 each  write strobes
//  halted       out  1  1 while in TRAP
// BEHAVIOUR
//  Reset: state=FETCH; all strobes are 0 while reset=1; halted=0. Other outputs take their FETCH values.
//  Outputs are combinational from state, except pc_write in BEQ (=zero) and imm_src (from op).
//  Any signal not listed for a state is 0.
//  FETCH: adr_src=0, a=00, b=10, ADD, result_src=10; ir_write=pc_write=mem_ready.
//   ->DECODE if mem_ready, else stay.
//  DECODE: a=01, b=01, ADD (branch target). Next state by op:
//   0000011/0100011 ->MEMADR; 0110011 ->EXECUTER; 0010011 ->EXECUTEI;
//   1100011 ->BEQ; 1101111 ->JAL; anything else ->TRAP.
//  MEMADR: a=10, b=01, ADD. ->MEMREAD if op=lw, else ->MEMWRITE.
//  MEMREAD: adr_src=1, result_src=00. ->MEMWB if mem_ready, else stay.
//  MEMWB: result_src=01, reg_write=1. ->FETCH.
//  MEMWRITE: adr_src=1, result_src=00; mem_write=1 held until mem_ready. ->FETCH on mem_ready.
//  EXECUTER: a=10, b=00, funct decode. ->ALUWB.
//  EXECUTEI: a=10, b=01, funct decode. ->ALUWB.
//  ALUWB: result_src=00, reg_write=1. ->FETCH.
//  BEQ: a=10, b=00, SUB, result_src=00, pc_write=zero. ->FETCH.
//  JAL: a=01, b=10, ADD, result_src=00, pc_write=1. ->ALUWB (writes rd=PC+4).
//  TRAP: all strobes 0, halted=1. Absorbing; left only through reset.
//  Latency with mem_ready=1: lw 5; sw/R/I/jal 4; beq 3 cycles. Each mem_ready=0 cycle adds 1.
//  Funct decode: funct3 000 -> SUB if funct7b5&op[5], else ADD; 010 -> SLT; 110 -> OR; 111 -> AND.
//   Any other funct3 (001,011,100,101) in EXECUTER/EXECUTEI -> TRAP on the next edge; no ALUWB.
//  Reset mid-instruction: the state returns to FETCH at once (async). No strobe fires in the reset cycle.
//  Illegal state encodings -> FETCH.
// STRUCTURE
//  Shared package ctrl_pkg:
//   state encoding (12 states); ula_control codes; opcode constants;
//   alu_src/result_src/imm_src encodings.
//  Sub-module alu_decoder: combinational (alu_op[1:0], funct3, funct7b5, op5) -> ula_control, funct_illegal.
//   alu_op: 00 add, 01 sub, 10 funct.
// TESTING
//  lw (op=0000011), mem_ready=1 -> states F,D,MA,MR,MWB.
//   reg_write=1 only in cycle 5 with result_src=01.
//  add/sub R-type: funct3=000, funct7b5=0 -> ula_control=010 in EXECUTER; funct7b5=1 -> 110.
//   I-type with funct7b5=1 -> 010 (no SUB).
//  beq: zero=1 -> pc_write=1 in cycle 3; zero=0 -> pc_write=0. Both return to FETCH.
//  sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write held 4 cycles.
//   FETCH follows the ready cycle; reg_write never asserted.
//  op=1110011 -> TRAP after DECODE, halted=1, strobes 0 for 20 cycles.
//   Reset pulse -> FETCH, halted=0.
//  Reset asserted in MEMWRITE mid-wait -> mem_write drops in the same cycle. After release: FETCH, ir_write=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALU op classes,
// ula_control codes, opcodes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format follows the opcode alone, independent of FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_BEQ:  sel = IMM_B;
      OP_JAL:  sel = IMM_J;
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: op class plus funct fields -> ula_control, and a flag for
// funct3 values outside the executed subset. Zero latency, no flow control.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output logic [2:0]  ula_control,
  output logic        funct_illegal
);

  always_comb begin
    ula_control   = ULA_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALU_ADD: ula_control = ULA_ADD;
      ALU_SUB: ula_control = ULA_SUB;
      ALU_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type: addi has no SUB form
          3'b000:  ula_control = (funct7b5 & op5) ? ULA_SUB : ULA_ADD;
          3'b010:  ula_control = ULA_SLT;
          3'b110:  ula_control = ULA_OR;
          3'b111:  ula_control = ULA_AND;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: ula_control = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I datapath (lw/sw/R/I/beq/jal, else TRAP).
// lw 5, sw/R/I/jal 4, beq 3 cycles; FETCH/MEMREAD/MEMWRITE stall while mem_ready is low.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  ula_control,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        halted
);

  state_t     state, next_state;
  alu_op_t    alu_op;
  logic       alu_en;
  logic [2:0] dec_ula;
  logic       funct_illegal;
  logic       mem_rdy;
  logic       ir_write_s, pc_write_s, reg_write_s, mem_write_s;

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .op5           (op[5]),
    .ula_control   (dec_ula),
    .funct_illegal (funct_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    alu_op      = ALU_ADD;
    alu_en      = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_en     = 1'b1;
        result_src = RES_ALURESULT;
        ir_write_s = mem_rdy;
        pc_write_s = mem_rdy;
        if (mem_rdy) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_en    = 1'b1;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTER;
          OP_ITYPE:     next_state = S_EXECUTEI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_en     = 1'b1;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_rdy) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_MEMDATA;
        reg_write_s = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        if (mem_rdy) next_state = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
        alu_op     = ALU_FUNCT;
        alu_en     = 1'b1;
        next_state = funct_illegal ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        next_state  = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_SUB;
        alu_en     = 1'b1;
        pc_write_s = zero;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_en     = 1'b1;
        pc_write_s = 1'b1;
        next_state = S_ALUWB;
      end
      S_TRAP: begin
        halted     = 1'b1;
        next_state = S_TRAP;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // States that do not use the ALU present ula_control = 000.
  assign ula_control = alu_en ? dec_ula : 3'b000;
  assign imm_src     = imm_src_of(op);

  // Reset is applied asynchronously, so strobes are masked for the whole reset cycle.
  assign ir_write  = ir_write_s  & ~reset;
  assign pc_write  = pc_write_s  & ~reset;
  assign reg_write = reg_write_s & ~reset;
  assign mem_write = mem_write_s & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a per-instruction phase-list model of the control unit.
module tb_multicycle_control;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic [2:0] ula_control;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, halted;

  int n_tests = 0;
  int n_fail  = 0;
  bit ready_q[$];
  logic [6:0] bad_ops [6];

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .ula_control(ula_control),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .mem_write(mem_write), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
    end
  endtask

  function automatic bit funct_legal(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic [2:0] funct_ula(input logic [2:0] f3, input logic f7, input logic [6:0] o);
    case (f3)
      3'd0:    return (f7 && o == RT) ? 3'b110 : 3'b010;
      3'd2:    return 3'b111;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle of a named instruction phase, packed as
  // {ula, a, b, result, imm, adr, ir_w, pc_w, reg_w, mem_w, halted}.
  function automatic logic [16:0] expect_of(input string ph, input bit mr);
    logic [2:0] u; logic [1:0] a, b, r, im;
    logic ad, irw, pcw, rw, mw, h;
    u = 3'b000; a = 2'd0; b = 2'd0; r = 2'd0; ad = 0; irw = 0; pcw = 0; rw = 0; mw = 0; h = 0;
    im = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
    case (ph)
      "F":    begin b = 2'd2; u = 3'b010; r = 2'd2; irw = mr; pcw = mr; end
      "RST":  begin b = 2'd2; u = 3'b010; r = 2'd2; end
      "D":    begin a = 2'd1; b = 2'd1; u = 3'b010; end
      "MA":   begin a = 2'd2; b = 2'd1; u = 3'b010; end
      "MR":   ad = 1;
      "MWB":  begin r = 2'd1; rw = 1; end
      "MW":   begin ad = 1; mw = 1; end
      "ER":   begin a = 2'd2; b = 2'd0; u = funct_ula(funct3, funct7b5, op); end
      "EI":   begin a = 2'd2; b = 2'd1; u = funct_ula(funct3, funct7b5, op); end
      "WB":   rw = 1;
      "BEQ":  begin a = 2'd2; b = 2'd0; u = 3'b110; pcw = zero; end
      "JAL":  begin a = 2'd1; b = 2'd2; u = 3'b010; pcw = 1; end
      "TRAP": h = 1;
      default: ;
    endcase
    return {u, a, b, r, im, ad, irw, pcw, rw, mw, h};
  endfunction

  task automatic compare(input string ph, input bit mr);
    logic [16:0] got, want;
    got  = {ula_control, alu_src_a, alu_src_b, result_src, imm_src,
            adr_src, ir_write, pc_write, reg_write, mem_write, halted};
    want = expect_of(ph, mr);
    // ALU code for an unsupported funct3 is unconstrained; only its trap is observable.
    if ((ph == "ER" || ph == "EI") && !funct_legal(funct3)) begin
      got[16:14]  = 3'b000;
      want[16:14] = 3'b000;
    end
    check_eq(ph, {15'd0, got}, {15'd0, want});
  endtask

  function automatic bit next_ready();
    if (ready_q.size() > 0) return ready_q.pop_front();
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic step(input string ph, output bit mr);
    mr = next_ready();
    mem_ready = mr;
    @(negedge clk);
    compare(ph, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    compare("RST", mem_ready);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic trap_run(input int n);
    bit mr;
    repeat (n) step("TRAP", mr);
    do_reset();
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int trap_len);
    bit mr;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    do step("F", mr); while (!mr);
    step("D", mr);
    case (o)
      LW: begin step("MA", mr); do step("MR", mr); while (!mr); step("MWB", mr); end
      SW: begin step("MA", mr); do step("MW", mr); while (!mr); end
      RT: begin step("ER", mr); if (funct_legal(f3)) step("WB", mr); else trap_run(trap_len); end
      IT: begin step("EI", mr); if (funct_legal(f3)) step("WB", mr); else trap_run(trap_len); end
      BQ: step("BEQ", mr);
      JL: begin step("JAL", mr); step("WB", mr); end
      default: trap_run(trap_len);
    endcase
  endtask

  initial begin
    bit mr;
    logic [6:0] o;
    logic [2:0] f3;
    int pick;
    bad_ops[0] = 7'b1110011; bad_ops[1] = 7'b0010111; bad_ops[2] = 7'b0110111;
    bad_ops[3] = 7'b1100111; bad_ops[4] = 7'b0001111; bad_ops[5] = 7'b1111111;

    reset = 1'b1; op = LW; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    #3;
    compare("RST", 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases
    ready_q = {1, 1, 1, 1, 1};
    run_instr(LW, 3'd2, 1'b0, 1'b0, 3);
    ready_q = {1, 1, 1};
    run_instr(RT, 3'd0, 1'b0, 1'b0, 3);
    ready_q = {1, 1, 1};
    run_instr(RT, 3'd0, 1'b1, 1'b0, 3);
    ready_q = {1, 1, 1};
    run_instr(IT, 3'd0, 1'b1, 1'b0, 3);
    ready_q = {1, 1, 1};
    run_instr(BQ, 3'd0, 1'b0, 1'b1, 3);
    ready_q = {1, 1, 1};
    run_instr(BQ, 3'd0, 1'b0, 1'b0, 3);
    ready_q = {1, 1, 1, 0, 0, 0, 1};
    run_instr(SW, 3'd2, 1'b0, 1'b0, 3);
    ready_q = {1, 1};
    run_instr(7'b1110011, 3'd0, 1'b0, 1'b0, 20);
    ready_q = {1, 1, 1};
    run_instr(RT, 3'd1, 1'b0, 1'b0, 4);

    // Reset while MEMWRITE is waiting on memory
    op = SW; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    ready_q = {1, 1, 1, 0, 0};
    step("F", mr); step("D", mr); step("MA", mr); step("MW", mr); step("MW", mr);
    do_reset();
    ready_q = {1, 1, 1, 1, 1};
    run_instr(LW, 3'd2, 1'b0, 1'b0, 3);

    // Random instruction stream with random memory stalls
    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 12);
      case (pick)
        0, 1:    o = LW;
        2, 3:    o = SW;
        4, 5:    o = RT;
        6, 7:    o = IT;
        8, 9:    o = BQ;
        10, 11:  o = JL;
        default: o = bad_ops[$urandom_range(0, 5)];
      endcase
      f3 = ($urandom_range(0, 9) < 8) ? 3'(($urandom_range(0, 3) == 0) ? 0 :
                                            ($urandom_range(0, 2) == 0) ? 2 :
                                            ($urandom_range(0, 1) == 0) ? 6 : 7)
                                      : 3'($urandom_range(0, 7));
      run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
